// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-control types and constants for the hazard unit.
package riscv_pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;
  typedef enum logic {RUN, MD_BUSY} hdu_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc && !(&r_q)) r_q <= r_q + 1'b1;
  end
  assign o_q = r_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush controller for the 5-stage RV32 pipeline,
// covering dmem waits, multi-cycle mul/div, redirects and load-use hazards.
module hazard_detection_unit
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IfId_regRs1,
  input  logic [REG_W-1:0] IfId_regRs2,
  input  logic             IfId_useRs1,
  input  logic             IfId_useRs2,
  input  logic             IdEx_memRead,
  input  logic [REG_W-1:0] IdEx_regRd,
  input  logic             Ex_branchTkn,
  input  logic             Ex_mdStart,
  input  logic             Ex_mdDone,
  input  logic             ExMem_memReq,
  input  logic             dmem_ready,
  output logic             pcWEn,
  output logic             IfIdWEn,
  output logic             IdExWEn,
  output logic             ExMemWEn,
  output logic             IfIdFlush,
  output logic             IdExFlush,
  output logic             ExMemFlush,
  output logic             MemWbFlush,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCycles
);
  localparam int WD_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  hdu_state_e r_state, w_next;
  logic            r_flush_pend, r_md_timeout;
  logic [WD_W-1:0] w_wd_cnt;
  logic            w_wd_hit, w_md_done, w_mem_wait, w_md_busy, w_redirect, w_load_use, w_free;

  assign w_wd_hit   = (r_state == MD_BUSY) && (w_wd_cnt == WD_W'(MD_TIMEOUT - 1));
  assign w_md_done  = Ex_mdDone | w_wd_hit;
  assign w_mem_wait = ExMem_memReq & ~dmem_ready;
  assign w_md_busy  = ((r_state == MD_BUSY) | Ex_mdStart) & ~w_md_done;
  assign w_redirect = Ex_branchTkn | r_flush_pend;
  assign w_load_use = IdEx_memRead && (IdEx_regRd != REG_X0) &&
                      ((IfId_useRs1 && IfId_regRs1 == IdEx_regRd) ||
                       (IfId_useRs2 && IfId_regRs2 == IdEx_regRd));
  assign w_free     = ~w_mem_wait & ~w_md_busy;

  // A redirect outranks load-use: the ID instruction is wrong-path and gets flushed anyway.
  always_comb begin
    pcWEn      = rst_n & w_free & ~(~w_redirect & w_load_use);
    IfIdWEn    = pcWEn;
    IdExWEn    = rst_n & w_free;
    ExMemWEn   = rst_n & ~w_mem_wait;
    IfIdFlush  = ~rst_n | (w_free & w_redirect);
    IdExFlush  = ~rst_n | (w_free & (w_redirect | w_load_use));
    ExMemFlush = ~rst_n | (~w_mem_wait & w_md_busy);
    MemWbFlush = ~rst_n | w_mem_wait;
  end

  // A dmem wait freezes the whole EX side, so MD_BUSY may not exit even on done/watchdog.
  always_comb begin
    w_next = (r_state == RUN) ? ((Ex_mdStart & ~Ex_mdDone) ? MD_BUSY : RUN)
                              : ((~w_mem_wait & w_md_done) ? RUN : MD_BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_flush_pend <= w_free ? 1'b0 : (r_flush_pend | Ex_branchTkn);
      if (w_wd_hit && !Ex_mdDone && !w_mem_wait) r_md_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(WD_W)) u_wd (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(r_state == RUN),
    .i_inc((r_state == MD_BUSY) & ~w_wd_hit),
    .o_q  (w_wd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(1'b0),
    .i_inc(~pcWEn),
    .o_q  (stallCycles)
  );

  assign mdTimeout = r_md_timeout;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed checks of stall/flush vectors, counters and watchdog.
module tb_hazard_detection_unit;
  logic       clk = 0, rst_n = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic       use1 = 0, use2 = 0, mem_read = 0, br = 0, md_start = 0, md_done = 0, mem_req = 0, ready = 0;
  logic       pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_fl, idex_fl, exmem_fl, memwb_fl, md_to;
  logic [31:0] stalls;
  int tests = 0, fails = 0;

  localparam logic [7:0] V_RUN = 8'b1111_0000, V_RST = 8'b0000_1111, V_LU = 8'b0011_0100;
  localparam logic [7:0] V_MEM = 8'b0000_0001, V_MD = 8'b0001_0010, V_RED = 8'b1111_1100;

  hazard_detection_unit #(.CNT_W(32), .MD_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .IfId_regRs1(rs1), .IfId_regRs2(rs2), .IfId_useRs1(use1), .IfId_useRs2(use2),
    .IdEx_memRead(mem_read), .IdEx_regRd(rd), .Ex_branchTkn(br),
    .Ex_mdStart(md_start), .Ex_mdDone(md_done), .ExMem_memReq(mem_req), .dmem_ready(ready),
    .pcWEn(pc_wen), .IfIdWEn(ifid_wen), .IdExWEn(idex_wen), .ExMemWEn(exmem_wen),
    .IfIdFlush(ifid_fl), .IdExFlush(idex_fl), .ExMemFlush(exmem_fl), .MemWbFlush(memwb_fl),
    .mdTimeout(md_to), .stallCycles(stalls)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_fl, idex_fl, exmem_fl, memwb_fl}, {24'd0, exp});
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    outs("reset_outs", V_RST);
    check("reset_stall", stalls, 0);
    check("reset_to", {31'd0, md_to}, 0);
    cyc(); rst_n = 1; #1;
    outs("run_idle", V_RUN);
    cyc(); mem_read = 1; rd = 5; rs2 = 5; use2 = 1; #1;
    outs("load_use", V_LU);
    check("lu_stall_before", stalls, 0);
    cyc(); mem_read = 0; #1;
    outs("lu_release", V_RUN);
    check("lu_stall_after", stalls, 1);
    cyc(); mem_read = 1; rd = 0; rs1 = 0; use1 = 1; rs2 = 0; #1;
    outs("x0_no_lu", V_RUN);
    cyc(); mem_read = 0; use1 = 0; use2 = 0; #1;
    check("x0_stall", stalls, 1);
    mem_req = 1; ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      outs("mem_wait", V_MEM);
      cyc();
    end
    ready = 1; #1;
    outs("mem_ready", V_RUN);
    check("mem_stall", stalls, 4);
    cyc(); mem_req = 1; ready = 0; br = 1; #1;
    outs("red_wait1", V_MEM);
    cyc(); br = 0; #1;
    outs("red_wait2", V_MEM);
    cyc(); mem_req = 0; #1;
    outs("red_apply", V_RED);
    cyc(); #1;
    outs("red_done", V_RUN);
    check("red_stall", stalls, 6);
    md_start = 1; #1;
    outs("md_start", V_MD);
    cyc(); md_start = 0; #1;
    for (int i = 0; i < 4; i++) begin
      outs("md_busy", V_MD);
      cyc();
    end
    md_done = 1; #1;
    outs("md_done", V_RUN);
    check("md_stall", stalls, 11);
    cyc(); md_done = 0; #1;
    outs("md_after", V_RUN);
    md_start = 1; md_done = 1; #1;
    outs("md_same_cycle", V_RUN);
    cyc(); md_start = 0; md_done = 0; #1;
    outs("md_same_next", V_RUN);
    md_start = 1; #1;
    outs("wd_start", V_MD);
    cyc(); md_start = 0; #1;
    for (int i = 0; i < 7; i++) begin
      outs("wd_busy", V_MD);
      check("wd_flag_low", {31'd0, md_to}, 0);
      cyc();
    end
    outs("wd_hit", V_RUN);
    check("wd_stall", stalls, 19);
    cyc(); #1;
    check("wd_flag", {31'd0, md_to}, 1);
    outs("wd_run", V_RUN);
    mem_read = 1; rd = 0; rs1 = 0; use1 = 1; #1;
    outs("wd_x0", V_RUN);
    cyc(); rd = 7; rs1 = 7; br = 1; #1;
    outs("red_over_lu", V_RED);
    check("wd_sticky", {31'd0, md_to}, 1);
    cyc(); mem_read = 0; use1 = 0; br = 0; md_start = 1; #1;
    outs("rst_md_start", V_MD);
    cyc(); md_start = 0; #1;
    outs("rst_md_busy", V_MD);
    #2; rst_n = 0; #1;
    outs("rst_mid", V_RST);
    check("rst_mid_stall", stalls, 0);
    check("rst_mid_to", {31'd0, md_to}, 0);
    cyc(); rst_n = 1; #1;
    outs("rst_release", V_RUN);
    cyc(); #1;
    outs("rst_after", V_RUN);
    check("rst_after_stall", stalls, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
